// File: rtl/auth_resp_scheduler.sv
// Responder-side sequencer for USB Type-C Authentication answers: dispatches a decoded request
// to its answer generator, latches the answer and streams it MSB-first one byte per handshake.
module auth_resp_scheduler #(
    parameter int unsigned HDR_W     = 32,
    parameter int unsigned PAY_W     = 96,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [7:0]  PROTO_VER = 8'h01
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [7:0]           req_type,
    output logic                 req_ready,
    output logic [2:0]           gen_ack_in,
    input  logic [2:0]           gen_ack_out,
    input  logic [3*HDR_W-1:0]   gen_header,
    input  logic [3*PAY_W-1:0]   gen_payload,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic                 busy
);

    localparam int unsigned MSG_W   = HDR_W + PAY_W;
    localparam int unsigned MSG_LEN = HDR_W / 8 + PAY_W / 8;
    localparam int unsigned LEN_W   = $clog2(MSG_LEN + 1);
    localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  ERR_UNSUPPORTED = 8'h07;
    localparam logic [7:0]  ERR_TIMEOUT     = 8'h04;

    typedef enum logic [1:0] {IDLE, DISPATCH, SEND} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [MSG_W-1:0]    msg_q, msg_d;
    logic [LEN_W-1:0]    len_q, len_d, idx_q, idx_d;
    logic                sel_ack;
    logic [MSG_W-1:0]    sel_msg;
    logic [2:0]          gen_ack_in_d;
    logic                tx_valid_d, tx_last_d, busy_d, req_ready_d;
    logic [7:0]          tx_data_d;

    // ERROR message occupies the header bytes; the payload part is never sent (len 4)
    function automatic logic [MSG_W-1:0] err_msg(input logic [7:0] code);
        err_msg = {PROTO_VER, 8'h7F, code, 8'h00, (MSG_W-32)'(0)};
    endfunction

    // Answer of the selected generator
    always_comb begin
        sel_ack = gen_ack_out[0];
        sel_msg = {gen_header[HDR_W-1:0], gen_payload[PAY_W-1:0]};
        case (sel_q)
            2'd1: begin
                sel_ack = gen_ack_out[1];
                sel_msg = {gen_header[2*HDR_W-1:HDR_W], gen_payload[2*PAY_W-1:PAY_W]};
            end
            2'd2: begin
                sel_ack = gen_ack_out[2];
                sel_msg = {gen_header[3*HDR_W-1:2*HDR_W], gen_payload[3*PAY_W-1:2*PAY_W]};
            end
            default: ;
        endcase
    end

    // Next state plus next values of the registered outputs
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        msg_d   = msg_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_type == 8'h81 || req_type == 8'h82 || req_type == 8'h83) begin
                        state_d = DISPATCH;
                        sel_d   = req_type[1:0] - 2'd1;
                        wait_d  = '0;
                    end else begin
                        state_d = SEND;
                        msg_d   = err_msg(ERR_UNSUPPORTED);
                        len_d   = LEN_W'(4);
                        idx_d   = '0;
                    end
                end
            end
            DISPATCH: begin
                wait_d = wait_q + WAIT_W'(1);
                if (sel_ack) begin
                    state_d = SEND;
                    msg_d   = sel_msg;
                    len_d   = LEN_W'(MSG_LEN);
                    idx_d   = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = SEND;
                    msg_d   = err_msg(ERR_TIMEOUT);
                    len_d   = LEN_W'(4);
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = IDLE;
                        msg_d   = '0;
                        len_d   = '0;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                        msg_d = msg_q << 8;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        gen_ack_in_d = (state_d == DISPATCH) ? (3'b001 << sel_d) : 3'b000;
        tx_valid_d   = (state_d == SEND);
        tx_data_d    = tx_valid_d ? msg_d[MSG_W-1 -: 8] : 8'h00;
        tx_last_d    = tx_valid_d && (idx_d == len_d - LEN_W'(1));
        busy_d       = (state_d != IDLE);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            wait_q     <= '0;
            msg_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            gen_ack_in <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_last    <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wait_q     <= wait_d;
            msg_q      <= msg_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            gen_ack_in <= gen_ack_in_d;
            tx_valid   <= tx_valid_d;
            tx_data    <= tx_data_d;
            tx_last    <= tx_last_d;
            busy       <= busy_d;
            req_ready  <= req_ready_d;
        end
    end

endmodule

// File: tb/tb_auth_resp_scheduler.sv
// Scoreboard bench for auth_resp_scheduler: expected bytes are queued when a request is issued
// and popped by a monitor on every tx handshake.
module tb_auth_resp_scheduler;

    localparam int HDR_W = 32;
    localparam int PAY_W = 96;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               req_valid = 1'b0;
    logic [7:0]         req_type = 8'h00;
    logic               req_ready;
    logic [2:0]         gen_ack_in;
    logic [2:0]         gen_ack_out;
    logic [3*HDR_W-1:0] gen_header = '0;
    logic [3*PAY_W-1:0] gen_payload = '0;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_last;
    logic               tx_ready = 1'b1;
    logic               busy;

    int checks = 0;
    int failures = 0;

    logic [2:0] gen_en = 3'b111;
    logic [2:0] spurious = 3'b000;
    int         rdy_mode = 0;
    int         rdy_cnt = 0;

    logic [8:0] sb[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    auth_resp_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
        .req_ready(req_ready), .gen_ack_in(gen_ack_in), .gen_ack_out(gen_ack_out),
        .gen_header(gen_header), .gen_payload(gen_payload), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered answer generators: ack one cycle after Ack_in when enabled, plus forced acks
    always @(posedge clk) begin
        if (reset) gen_ack_out <= 3'b000;
        else       gen_ack_out <= (gen_ack_in & gen_en) | spurious;
    end

    // Downstream readiness: always ready, or the 1,0,0 repeating pattern
    always @(posedge clk) begin
        #1;
        rdy_cnt = rdy_cnt + 1;
        tx_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_cnt % 3) == 0);
    end

    // Scoreboard monitor: byte order, tx_last placement and stall stability
    always @(negedge clk) begin
        logic [8:0] exp;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                             tx_valid, tx_data, tx_last, prev_data, prev_last);
                end
            end
            if (tx_valid === 1'b1 && tx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte got data=%h last=%b want no byte", tx_data, tx_last);
                end else begin
                    exp = sb.pop_front();
                    if ({tx_last, tx_data} !== exp) begin
                        failures++;
                        $display("FAIL tx_byte got data=%h last=%b want data=%h last=%b",
                                 tx_data, tx_last, exp[7:0], exp[8]);
                    end
                end
            end
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic push_msg(input logic [HDR_W-1:0] hdr, input logic [PAY_W-1:0] pay);
        logic [HDR_W+PAY_W-1:0] m;
        m = {hdr, pay};
        for (int i = 0; i < (HDR_W + PAY_W) / 8; i++)
            sb.push_back({i == (HDR_W + PAY_W) / 8 - 1, m[HDR_W+PAY_W-1-8*i -: 8]});
    endtask

    task automatic push_err(input logic [7:0] code);
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h7F});
        sb.push_back({1'b0, code});
        sb.push_back({1'b1, 8'h00});
    endtask

    // Present a request until accepted; returns #1 after the accepting edge
    task automatic send_req(input logic [7:0] t);
        int n;
        n = 0;
        @(negedge clk);
        req_type = t;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_accept got req_ready=%b want 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || gen_ack_in !== 3'b000 || req_ready !== 1'b1 || busy !== 1'b0 ||
            tx_data !== 8'h00 || tx_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got valid=%b ack_in=%b ready=%b busy=%b data=%h last=%b want 0 000 1 0 00 0",
                     tx_valid, gen_ack_in, req_ready, busy, tx_data, tx_last);
        end
        reset = 1'b0;
    endtask

    task automatic test_digests();
        logic [7:0] exp_bytes [16];
        int acks, n;
        bit ok;
        exp_bytes = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h04, 8'h56, 8'h87, 8'h87,
                      8'hAC, 8'h78, 8'h64, 8'h25, 8'h0F, 8'h98, 8'h65, 8'h50};
        gen_header[HDR_W-1:0]  = 32'h01010107;
        gen_payload[PAY_W-1:0] = 96'h04568787_AC786425_0F986550;
        gen_en = 3'b111;
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) sb.push_back({i == 15, exp_bytes[i]});
        send_req(8'h81);
        acks = 0;
        n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin
            if (gen_ack_in === 3'b001) acks++;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (acks != 2) begin
            failures++;
            $display("FAIL digests_ack_cycles got %0d want 2", acks);
        end
        checks++;
        if (gen_ack_in !== 3'b000) begin
            failures++;
            $display("FAIL digests_ack_drop got %b want 000", gen_ack_in);
        end
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL digests_drain got %0d bytes left want 0", sb.size());
        end
        checks++;
        if (tx_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL digests_idle got valid=%b ready=%b busy=%b want 0 1 0", tx_valid, req_ready, busy);
        end
    endtask

    task automatic test_unsupported();
        bit ok;
        push_err(8'h07);
        send_req(8'h10);
        checks++;
        if (gen_ack_in !== 3'b000 || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL unsup_direct got ack_in=%b valid=%b want 000 1", gen_ack_in, tx_valid);
        end
        wait_drain(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL unsup_drain got %0d bytes left want 0", sb.size());
        end
        checks++;
        if (tx_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL unsup_idle got valid=%b ready=%b want 0 1", tx_valid, req_ready);
        end
    endtask

    task automatic test_timeout();
        int acks, n;
        bit ok;
        gen_en = 3'b011;
        push_err(8'h04);
        send_req(8'h83);
        acks = 0;
        n = 0;
        while (tx_valid !== 1'b1 && n < 100) begin
            if (gen_ack_in === 3'b100) acks++;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (acks != 16) begin
            failures++;
            $display("FAIL timeout_ack_cycles got %0d want 16", acks);
        end
        wait_drain(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_drain got %0d bytes left want 0", sb.size());
        end
        gen_en = 3'b111;
    endtask

    task automatic test_stall();
        bit ok;
        gen_header[2*HDR_W-1:HDR_W]  = 32'h01820011;
        gen_payload[2*PAY_W-1:PAY_W] = 96'hDEADBEEF_00112233_A5C30FF0;
        rdy_mode = 1;
        push_msg(32'h01820011, 96'hDEADBEEF_00112233_A5C30FF0);
        send_req(8'h82);
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_drain got %0d bytes left want 0", sb.size());
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle got valid=%b busy=%b want 0 0", tx_valid, busy);
        end
        rdy_mode = 0;
    endtask

    task automatic test_mid_reset();
        int n;
        bit ok;
        gen_header[HDR_W-1:0]  = 32'h01010107;
        gen_payload[PAY_W-1:0] = 96'h04568787_AC786425_0F986550;
        push_msg(32'h01010107, 96'h04568787_AC786425_0F986550);
        send_req(8'h81);
        n = 0;
        while (sb.size() > 11 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || gen_ack_in !== 3'b000 || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state got valid=%b ack_in=%b ready=%b busy=%b want 0 000 1 0",
                     tx_valid, gen_ack_in, req_ready, busy);
        end
        reset = 1'b0;
        sb.delete();
        push_msg(32'h01010107, 96'h04568787_AC786425_0F986550);
        send_req(8'h81);
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_drain got %0d bytes left want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int n, extra;
        bit ok;
        gen_header[HDR_W-1:0]        = 32'h01010107;
        gen_payload[PAY_W-1:0]       = 96'h11223344_55667788_99AABBCC;
        gen_header[2*HDR_W-1:HDR_W]  = 32'hFFFFFFFF;
        gen_payload[2*PAY_W-1:PAY_W] = {12{8'hEE}};
        gen_en = 3'b000;
        spurious = 3'b010;
        push_msg(32'h01010107, 96'h11223344_55667788_99AABBCC);
        send_req(8'h81);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (gen_ack_in !== 3'b001 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrong_gen_ignored got ack_in=%b valid=%b want 001 0", gen_ack_in, tx_valid);
        end
        spurious = 3'b000;
        gen_en = 3'b001;
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_type = 8'h10;
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || gen_ack_in !== 3'b000) begin
            failures++;
            $display("FAIL send_ignores_req got ready=%b ack_in=%b want 0 000", req_ready, gen_ack_in);
        end
        req_valid = 1'b0;
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_drain got %0d bytes left want 0", sb.size());
        end
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (tx_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL req_not_queued got %0d active cycles want 0", extra);
        end
        gen_en = 3'b111;
    endtask

    initial begin
        test_reset();
        test_digests();
        test_unsupported();
        test_timeout();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
